mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one external memory bus between the pipeline's IF stage (instruction fetch) and MEM stage (DM load/store).
//  Sequences each access through an idle/grant/wait/done FSM using the bus ready handshake.
//  Produces a stall that drives the pipeline's existing pause path; a watchdog completes transactions the bus never answers.
// PARAMETERS
//  TIMEOUT_CYC  255  max bus wait cycles per access before forced completion (>=1)
//  CNT_W        8    watchdog counter width; 2**CNT_W must exceed TIMEOUT_CYC
// PORTS
//  clk        in   1   system clock, rising edge
//  reset      in   1   asynchronous, active-high reset
//  if_req     in   1   fetch request; held until if_ack
//  if_addr    in   32  fetch address (PC)
//  if_rdata   out  32  fetched instruction, valid while if_ack=1
//  if_ack     out  1   one-cycle fetch completion pulse
//  dm_req     in   1   data request; held with its qualifiers until dm_ack
//  dm_we      in   1   1=store, 0=load
//  dm_ctrl    in   3   access size/sign code (dm_ctrl encoding)
//  dm_addr    in   32  data address
//  dm_wdata   in   32  store data
//  dm_rdata   out  32  load data, valid while dm_ack=1
//  dm_ack     out  1   one-cycle data completion pulse
//  bus_req    out  1   bus transaction active
//  bus_we     out  1   bus write enable
//  bus_ctrl   out  3   bus access size code
//  bus_addr   out  32  bus address
//  bus_wdata  out  32  bus write data
//  bus_rdata  in   32  bus read data, sampled when bus_ready=1
//  bus_ready  in   1   bus completion, sampled only while bus_req=1
//  stall      out  1   (if_req&~if_ack)|(dm_req&~dm_ack); combinational
//  bus_err    out  1   sticky: a watchdog timeout has occurred
// BEHAVIOUR
//  Reset (async): state IDLE; every registered output 0 (bus_req, bus_we, bus_ctrl, bus_addr, bus_wdata,
//   if/dm_rdata, if/dm_ack, bus_err); watchdog 0. An in-flight access is abandoned with no ack.
//  States: IDLE, DGNT (data on bus), IGNT (fetch on bus), DONE.
//  IDLE: dm_req -> DGNT; else if_req -> IGNT. Fixed priority: data first (older instruction).
//   On grant, register the bus_* fields: data copies dm_we/dm_ctrl/dm_addr/dm_wdata;
//   fetch drives bus_we=0, bus_ctrl=DM_WORD, bus_addr=if_addr. bus_req=1 from the next cycle.
//  DGNT/IGNT: bus_* fields held stable. Watchdog increments each cycle with bus_ready=0.
//   If bus_ready=1: capture bus_rdata into the granted rdata register, bus_req->0, go to DONE.
//   If watchdog==TIMEOUT_CYC-1 and bus_ready=0: rdata<=0, bus_err<=1, bus_req->0, go to DONE.
//   bus_ready=1 on the final watchdog cycle counts as normal completion; bus_err unchanged.
//  DONE: granted ack=1 for exactly this cycle; rdata held; watchdog cleared; go to IDLE.
//   New requests are not sampled in DONE, so a requester may present its next access on the ack cycle.
//  Min latency: request at cycle N, bus_req at N+1, bus_ready at N+1, ack at N+2.
//   Each wait cycle adds 1. Back-to-back accesses are spaced by 1 IDLE cycle.
//  Stores: dm_rdata is 0 on ack. Requester dropping req mid-access: the access still completes and still acks.
//  bus_req is never asserted in IDLE/DONE. Both acks are never high in the same cycle.
//  bus_err clears only on reset.
// STRUCTURE
//  Add to ctrl_encode_def.v: ARB_IDLE/ARB_DGNT/ARB_IGNT/ARB_DONE (2-bit encodings).
//   Reuse the existing DM_WORD access code from that file.
//  Sub-module arb_watchdog: counter, clear/enable inputs, expire output; parameterised by TIMEOUT_CYC/CNT_W.
//  Top level: FSM, bus output registers, rdata/ack registers, combinational stall.
// TESTING
//  1 Fetch only: if_req=1, if_addr=0x4; bus_ready=1 at cycle 1 with bus_rdata=0x00500093
//    -> bus_addr=0x4, bus_ctrl=DM_WORD at cycle 1; if_ack=1, if_rdata=0x00500093 at cycle 2; stall low at cycle 3.
//  2 Simultaneous if_req and dm_req (load at 0x100)
//    -> data is granted first, dm_ack at cycle 2; fetch is granted at cycle 3, if_ack at cycle 5; stall high until each ack.
//  3 Store: dm_we=1, dm_ctrl=byte code, dm_wdata=0xA5, dm_addr=0x203; bus_ready after 3 wait cycles
//    -> bus_we/bus_wdata/bus_addr stable throughout; dm_ack at cycle 5; dm_rdata=0.
//  4 TIMEOUT_CYC=4, load with bus_ready held at 0
//    -> bus_req low after 4 cycles; dm_ack with dm_rdata=0; bus_err=1 and stays 1 across later good accesses.
//  5 reset pulsed mid-DGNT
//    -> bus_req=0 with no clock edge; no dm_ack; the next request after reset is served normally.
//  6 Ready on the final watchdog cycle, TIMEOUT_CYC=4, bus_ready=1 at wait cycle 4
//    -> normal rdata captured; bus_err stays 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - arbiter FSM encodings and shared access-size codes
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_DGNT = 2'b01,
        ARB_IGNT = 2'b10,
        ARB_DONE = 2'b11
    } arb_state_t;

    localparam logic [2:0] DM_WORD = 3'b000;
    localparam logic [2:0] DM_BYTE = 3'b011;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and external bus signals of the port arbiter
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;

    logic        dm_req;
    logic        dm_we;
    logic [2:0]  dm_ctrl;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;

    logic        bus_req;
    logic        bus_we;
    logic [2:0]  bus_ctrl;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;

    logic        stall;
    logic        bus_err;

    // Pipeline and memory side: drives requests and bus responses.
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_ctrl, dm_addr, dm_wdata,
               bus_rdata, bus_ready,
        input  if_rdata, if_ack, dm_rdata, dm_ack,
               bus_req, bus_we, bus_ctrl, bus_addr, bus_wdata, stall, bus_err
    );

    // Arbiter view.
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_ctrl, dm_addr, dm_wdata,
               bus_rdata, bus_ready,
        output if_rdata, if_ack, dm_rdata, dm_ack,
               bus_req, bus_we, bus_ctrl, bus_addr, bus_wdata, stall, bus_err
    );
endinterface

// File: rtl/arb_watchdog.sv
// rtl/arb_watchdog.sv - bus wait-cycle counter that flags an unanswered access
module arb_watchdog #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = (cnt == CNT_W'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory bus between instruction fetch and data access
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic reset,
    mem_port_arbiter_if.slave port
);
    arb_state_t  state, state_nxt;

    logic        grant_d, grant_i, busy, finish_ok, finish_to;
    logic        wd_clear, wd_enable, wd_expire;

    logic        bus_req_r, bus_we_r, if_ack_r, dm_ack_r, bus_err_r;
    logic [2:0]  bus_ctrl_r;
    logic [31:0] bus_addr_r, bus_wdata_r, if_rdata_r, dm_rdata_r;
    logic [31:0] cap_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: begin
                if (port.dm_req) begin
                    state_nxt = ARB_DGNT;
                end else if (port.if_req) begin
                    state_nxt = ARB_IGNT;
                end
            end
            ARB_DGNT, ARB_IGNT: begin
                if (port.bus_ready || wd_expire) begin
                    state_nxt = ARB_DONE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // Data wins over fetch in IDLE: the data access belongs to the older instruction.
    always_comb begin
        grant_d   = (state == ARB_IDLE) && port.dm_req;
        grant_i   = (state == ARB_IDLE) && !port.dm_req && port.if_req;
        busy      = (state == ARB_DGNT) || (state == ARB_IGNT);
        finish_ok = busy && port.bus_ready;
        finish_to = busy && !port.bus_ready && wd_expire;
        wd_enable = busy && !port.bus_ready && !wd_expire;
        wd_clear  = !busy;
        cap_data  = finish_ok && !bus_we_r ? port.bus_rdata : 32'h0;
    end

    arb_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_ctrl_r  <= 3'b000;
            bus_addr_r  <= 32'h0;
            bus_wdata_r <= 32'h0;
            if_rdata_r  <= 32'h0;
            dm_rdata_r  <= 32'h0;
            if_ack_r    <= 1'b0;
            dm_ack_r    <= 1'b0;
            bus_err_r   <= 1'b0;
        end else begin
            if_ack_r <= 1'b0;
            dm_ack_r <= 1'b0;
            if (grant_d) begin
                bus_req_r   <= 1'b1;
                bus_we_r    <= port.dm_we;
                bus_ctrl_r  <= port.dm_ctrl;
                bus_addr_r  <= port.dm_addr;
                bus_wdata_r <= port.dm_wdata;
            end else if (grant_i) begin
                bus_req_r   <= 1'b1;
                bus_we_r    <= 1'b0;
                bus_ctrl_r  <= DM_WORD;
                bus_addr_r  <= port.if_addr;
            end
            // Stores and timeouts both return zero data; the ack lands in DONE.
            if (finish_ok || finish_to) begin
                bus_req_r <= 1'b0;
                if (state == ARB_DGNT) begin
                    dm_rdata_r <= cap_data;
                    dm_ack_r   <= 1'b1;
                end else begin
                    if_rdata_r <= cap_data;
                    if_ack_r   <= 1'b1;
                end
            end
            if (finish_to) begin
                bus_err_r <= 1'b1;
            end
        end
    end

    assign port.bus_req   = bus_req_r;
    assign port.bus_we    = bus_we_r;
    assign port.bus_ctrl  = bus_ctrl_r;
    assign port.bus_addr  = bus_addr_r;
    assign port.bus_wdata = bus_wdata_r;
    assign port.if_rdata  = if_rdata_r;
    assign port.if_ack    = if_ack_r;
    assign port.dm_rdata  = dm_rdata_r;
    assign port.dm_ack    = dm_ack_r;
    assign port.bus_err   = bus_err_r;
    assign port.stall     = (port.if_req && !if_ack_r) || (port.dm_req && !dm_ack_r);
endmodule
